sram_hd_req_ctrl: RTL

Initiator-side controller for the 128x4096 high-density single-port SRAM wrapper. It converts a valid/ready request stream (read/write, byte enables) into the macro's active-low CEN/GWEN/WEN port and absorbs the macro's fixed 1-cycle read latency. Read data returns through a credit-protected response FIFO, so consumer back-pressure never loses data. It sits between the core/DMA-side memory mux and the SRAM wrapper.

---
 rtl/sram_ctrl_pkg.sv | 29 ++
 rtl/sram_rsp_fifo.sv | 69 ++++++
 rtl/sram_hd_req_ctrl.sv | 102 ++++++++++
 3 files changed

// File: rtl/sram_ctrl_pkg.sv
// Shared configuration for the 128x4096 high-density SRAM controller.
// Contents:
//   DW, AW, BEW : data width, word-address width, byte-enable width
//   be2mask     : byte enables (active-high) -> active-low bit write mask
//   sram_req_t  : request payload as carried on the memory-mux side
package sram_ctrl_pkg;

  localparam int unsigned DW  = 128;
  localparam int unsigned AW  = 12;
  localparam int unsigned BEW = DW / 8;

  typedef struct packed {
    logic           we;
    logic [AW-1:0]  addr;
    logic [DW-1:0]  wdata;
    logic [BEW-1:0] be;
  } sram_req_t;

  // Each byte-enable bit clears (enables) its eight mask bits.
  function automatic logic [DW-1:0] be2mask(input logic [BEW-1:0] be);
    logic [DW-1:0] mask;
    mask = '1;
    for (int unsigned i = 0; i < BEW; i++) begin
      mask[i*8 +: 8] = {8{~be[i]}};
    end
    return mask;
  endfunction

endpackage

// File: rtl/sram_rsp_fifo.sv
// Synchronous response FIFO for SRAM read data.
// Ports:
//   clk, rst  : clock, synchronous active-high reset
//   i_push    : write i_wdata at the tail
//   i_pop     : drop the head entry (ignored when empty)
//   o_rdata   : head entry, stable until popped
//   o_count   : number of stored entries
//   o_full    : count == DEPTH
//   o_empty   : count == 0
module sram_rsp_fifo #(
  parameter  int unsigned DW    = 128,
  parameter  int unsigned DEPTH = 2,
  localparam int unsigned CW    = $clog2(DEPTH + 1)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          i_push,
  input  logic [DW-1:0] i_wdata,
  input  logic          i_pop,
  output logic [DW-1:0] o_rdata,
  output logic [CW-1:0] o_count,
  output logic          o_full,
  output logic          o_empty
);

  localparam int unsigned PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [DW-1:0] r_mem [DEPTH];
  logic [PW-1:0] r_wr_ptr;
  logic [PW-1:0] r_rd_ptr;
  logic [CW-1:0] r_count;
  logic          w_pop;

  // Pointer increment with wrap for any depth, not only powers of two.
  function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
    return (p == PW'(DEPTH - 1)) ? '0 : p + PW'(1);
  endfunction

  assign w_pop   = i_pop & ~o_empty;
  assign o_rdata = r_mem[r_rd_ptr];
  assign o_count = r_count;
  assign o_full  = (r_count == CW'(DEPTH));
  assign o_empty = (r_count == '0);

  // Storage array, no reset needed.
  always_ff @(posedge clk) begin
    if (i_push) begin
      r_mem[r_wr_ptr] <= i_wdata;
    end
  end

  // Pointers and occupancy.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (i_push) r_wr_ptr <= ptr_inc(r_wr_ptr);
      if (w_pop)  r_rd_ptr <= ptr_inc(r_rd_ptr);
      case ({i_push, w_pop})
        2'b10:   r_count <= r_count + CW'(1);
        2'b01:   r_count <= r_count - CW'(1);
        default: r_count <= r_count;
      endcase
    end
  end

endmodule

// File: rtl/sram_hd_req_ctrl.sv
// Initiator-side controller for the 128x4096 high-density single-port SRAM.
// Turns a valid/ready request stream into the macro's active-low port and
// returns read data through a credit-protected response FIFO.
// Ports:
//   CLK, RST               : clock, synchronous active-high reset
//   req_valid/req_ready    : request handshake
//   req_we/addr/wdata/be   : request payload (we=1 write, be active-high)
//   rsp_valid/rsp_ready    : read response handshake, rsp_rdata payload
//   CEN/GWEN/WEN/A/D       : SRAM drive (active-low enables and bit mask)
//   Q                      : SRAM read data, valid the cycle after a read
module sram_hd_req_ctrl #(
  parameter int unsigned DW        = sram_ctrl_pkg::DW,
  parameter int unsigned AW        = sram_ctrl_pkg::AW,
  parameter int unsigned RSP_DEPTH = 2
) (
  input  logic              CLK,
  input  logic              RST,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_we,
  input  logic [AW-1:0]     req_addr,
  input  logic [DW-1:0]     req_wdata,
  input  logic [DW/8-1:0]   req_be,
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic [DW-1:0]     rsp_rdata,
  output logic              CEN,
  output logic              GWEN,
  output logic [DW-1:0]     WEN,
  output logic [AW-1:0]     A,
  output logic [DW-1:0]     D,
  input  logic [DW-1:0]     Q
);

  localparam int unsigned BEW = DW / 8;
  localparam int unsigned CW  = $clog2(RSP_DEPTH + 1);
  localparam int unsigned OW  = CW + 1;

  logic          r_rd_inflight;
  logic          w_fire;
  logic          w_wr_fire;
  logic          w_pop;
  logic          w_full;
  logic          w_empty;
  logic [CW-1:0] w_count;
  logic [OW-1:0] w_occ;
  logic [DW-1:0] w_wmask;

  // Credit: buffered responses plus the read whose data lands this cycle.
  // A same-cycle pop frees a slot, which keeps reads streaming at depth 2.
  assign w_occ     = OW'(w_count) + OW'(r_rd_inflight);
  assign w_pop     = rsp_valid & rsp_ready;
  assign req_ready = ~RST & ((w_occ < OW'(RSP_DEPTH)) | w_pop);
  assign w_fire    = req_valid & req_ready;
  assign w_wr_fire = w_fire & req_we;

  // Byte enables to active-low bit mask.
  always_comb begin
    w_wmask = '1;
    for (int unsigned i = 0; i < BEW; i++) begin
      w_wmask[i*8 +: 8] = {8{~req_be[i]}};
    end
  end

  // SRAM port drive.
  assign CEN  = ~w_fire;
  assign GWEN = ~w_wr_fire;
  assign WEN  = w_wr_fire ? w_wmask : '1;
  assign A    = req_addr;
  assign D    = req_wdata;

  // Marks the cycle in which Q carries data for an accepted read.
  always_ff @(posedge CLK) begin
    if (RST) r_rd_inflight <= 1'b0;
    else     r_rd_inflight <= w_fire & ~req_we;
  end

  sram_rsp_fifo #(
    .DW    (DW),
    .DEPTH (RSP_DEPTH)
  ) u_rsp_fifo (
    .clk     (CLK),
    .rst     (RST),
    .i_push  (r_rd_inflight),
    .i_wdata (Q),
    .i_pop   (w_pop),
    .o_rdata (rsp_rdata),
    .o_count (w_count),
    .o_full  (w_full),
    .o_empty (w_empty)
  );

  assign rsp_valid = ~w_empty;

  // Credit guarantees a push never meets a full FIFO without a same-cycle pop.
  always_ff @(posedge CLK) begin
    if (!RST) begin
      assert (!(r_rd_inflight && w_full && !w_pop));
    end
  end

endmodule
